lsu_bus_master: RTL and testbench

Initiator side of the on-chip word-addressed data bus used by the core's memory-mapped peripherals and data RAM. Accepts one byte/half/word load or store per handshake from the core's memory stage, converts the byte address to a word address plus byte enables, and issues a single `clken` access. It then waits the responder's fixed read latency and returns aligned, sign- or zero-extended read data as a one-cycle response.

---
 rtl/lsu_pkg.sv | 6 +
 rtl/lsu_bus_master_align.sv | 24 ++
 rtl/lsu_bus_master.sv | 123 ++++++++++++
 tb/tb_lsu_bus_master.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and limits for the LSU bus master.
package lsu_pkg;
    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD} size_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;
    localparam int MAX_READ_LATENCY = 2;
endpackage

// File: rtl/lsu_bus_master_align.sv
// lsu_align: byte-lane enables, write-data replication and load-data extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_unsigned,
    input  logic [31:0] i_q,
    output logic [3:0]  o_byteena,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] w_shift;
    always_comb begin
        w_shift   = i_q >> {i_addr, 3'b000};
        o_byteena = (i_size == SIZE_BYTE) ? 4'b0001 << i_addr :
                    (i_size == SIZE_HALF) ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        o_wdata   = (i_size == SIZE_BYTE) ? {4{i_wdata[7:0]}} :
                    (i_size == SIZE_HALF) ? {2{i_wdata[15:0]}} : i_wdata;
        o_rdata   = (i_size == SIZE_BYTE) ? {{24{~i_unsigned & w_shift[7]}}, w_shift[7:0]} :
                    (i_size == SIZE_HALF) ? {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]} : w_shift;
    end
endmodule

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: single-outstanding load/store initiator on the word-addressed bus.
// LSU_MISALIGN_CHECK_EN rejects misaligned/reserved requests; otherwise low address bits are masked.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 14,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [31:0]           i_req_addr,
    input  logic                  i_req_write,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_resp_valid,
    output logic [31:0]           o_resp_rdata,
    output logic                  o_resp_error,
    output logic [ADDR_WIDTH-1:0] o_bus_address,
    output logic [3:0]            o_bus_byteena,
    output logic                  o_bus_clken,
    output logic                  o_bus_wren,
    output logic [31:0]           o_bus_data,
    input  logic [31:0]           i_bus_q
);
    localparam int CW = $clog2(MAX_READ_LATENCY);

    lsu_state_t r_state, w_state_nxt;
    logic [1:0] r_size, r_lo, w_req_size, w_req_lo, w_size, w_lo;
    logic r_unsigned, r_write, w_req_err;
    logic [CW-1:0] r_cnt;
    logic [3:0] w_byteena;
    logic [31:0] w_wdata, w_rdata;
    logic r_req_ready, r_resp_valid, r_resp_error, r_bus_clken, r_bus_wren;
    logic [31:0] r_resp_rdata, r_bus_data;
    logic [ADDR_WIDTH-1:0] r_bus_address;
    logic [3:0] r_bus_byteena;
    logic w_unused;

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_req_size = i_req_size;
    assign w_req_lo   = i_req_addr[1:0];
    assign w_req_err  = (i_req_size == SIZE_HALF && i_req_addr[0]) ||
                        (i_req_size == SIZE_WORD && i_req_addr[1:0] != 2'b00) || (i_req_size == SIZE_RSVD);
`else
    assign w_req_size = (i_req_size == SIZE_RSVD) ? SIZE_WORD : i_req_size;
    assign w_req_lo   = (w_req_size == SIZE_BYTE) ? i_req_addr[1:0] :
                        (w_req_size == SIZE_HALF) ? {i_req_addr[1], 1'b0} : 2'b00;
    assign w_req_err  = 1'b0;
`endif
    assign w_unused = ^i_req_addr[31:ADDR_WIDTH+2];

    // In IDLE the aligner sees the incoming request; afterwards the latched one for load data.
    assign w_size = (r_state == IDLE) ? w_req_size : r_size;
    assign w_lo   = (r_state == IDLE) ? w_req_lo : r_lo;

    lsu_align u_align (
        .i_size(w_size), .i_addr(w_lo), .i_wdata(i_req_wdata), .i_unsigned(r_unsigned), .i_q(i_bus_q),
        .o_byteena(w_byteena), .o_wdata(w_wdata), .o_rdata(w_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = i_req_valid ? (w_req_err ? RESP : ISSUE) : IDLE;
            ISSUE:   w_state_nxt = r_write ? RESP : WAIT;
            WAIT:    w_state_nxt = (r_cnt == '0) ? RESP : WAIT;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_error  <= 1'b0;
            r_resp_rdata  <= '0;
            r_bus_clken   <= 1'b0;
            r_bus_wren    <= 1'b0;
            r_bus_address <= '0;
            r_bus_byteena <= '0;
            r_bus_data    <= '0;
            r_size        <= '0;
            r_lo          <= '0;
            r_unsigned    <= 1'b0;
            r_write       <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_ready  <= w_state_nxt == IDLE;
            r_resp_valid <= w_state_nxt == RESP;
            r_resp_error <= r_state == IDLE && w_state_nxt == RESP;
            r_resp_rdata <= (r_state == WAIT && w_state_nxt == RESP) ? w_rdata : '0;
            r_bus_clken  <= w_state_nxt == ISSUE;
            r_bus_wren   <= w_state_nxt == ISSUE && i_req_write;
            if (r_state == IDLE && i_req_valid) begin
                r_size     <= w_req_size;
                r_lo       <= w_req_lo;
                r_unsigned <= i_req_unsigned;
                r_write    <= i_req_write;
            end
            if (w_state_nxt == ISSUE) begin
                r_bus_address <= i_req_addr[ADDR_WIDTH+1:2];
                r_bus_byteena <= w_byteena;
                r_bus_data    <= w_wdata;
            end
            r_cnt <= (r_state == ISSUE) ? CW'(READ_LATENCY - 1) : (r_state == WAIT) ? r_cnt - CW'(1) : r_cnt;
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_error  = r_resp_error;
    assign o_resp_rdata  = r_resp_rdata;
    assign o_bus_clken   = r_bus_clken;
    assign o_bus_wren    = r_bus_wren;
    assign o_bus_address = r_bus_address;
    assign o_bus_byteena = r_bus_byteena;
    assign o_bus_data    = r_bus_data;
endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master: random and directed transactions on READ_LATENCY=1 and =2 instances vs. a lane-level model.
module tb_lsu_bus_master;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic reqv [2];
    logic [31:0] req_addr = '0, req_wdata = '0, bus_q = '0;
    logic req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0] req_size = '0;
    logic ready [2], rvalid [2], rerror [2], clken [2], wren [2];
    logic [31:0] rdata [2], bdata [2];
    logic [13:0] baddr [2];
    logic [3:0] bbe [2];
    logic [13:0] h_addr [2];
    logic [3:0] h_be [2];
    logic [31:0] h_data [2];
    int nchk = 0, nerr = 0;

    always #5 clock = ~clock;

    lsu_bus_master #(.ADDR_WIDTH(14), .READ_LATENCY(1)) dut (
        .clock(clock), .reset_n(reset_n), .i_req_valid(reqv[0]), .o_req_ready(ready[0]),
        .i_req_addr(req_addr), .i_req_write(req_write), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
        .i_req_wdata(req_wdata), .o_resp_valid(rvalid[0]), .o_resp_rdata(rdata[0]), .o_resp_error(rerror[0]),
        .o_bus_address(baddr[0]), .o_bus_byteena(bbe[0]), .o_bus_clken(clken[0]), .o_bus_wren(wren[0]),
        .o_bus_data(bdata[0]), .i_bus_q(bus_q));

    lsu_bus_master #(.ADDR_WIDTH(14), .READ_LATENCY(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .i_req_valid(reqv[1]), .o_req_ready(ready[1]),
        .i_req_addr(req_addr), .i_req_write(req_write), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
        .i_req_wdata(req_wdata), .o_resp_valid(rvalid[1]), .o_resp_rdata(rdata[1]), .o_resp_error(rerror[1]),
        .o_bus_address(baddr[1]), .o_bus_byteena(bbe[1]), .o_bus_clken(clken[1]), .o_bus_wren(wren[1]),
        .o_bus_data(bdata[1]), .i_bus_q(bus_q));

    task automatic model(input logic [31:0] a, input logic [1:0] sz, input logic u, input logic [31:0] wd,
                         input logic [31:0] q, output logic err, output logic [3:0] be, output logic [31:0] d,
                         output logic [31:0] rd);
        int n, off;
        logic [63:0] v, m;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a[1:0]);
`ifdef LSU_MISALIGN_CHECK_EN
        err = (sz == 2'd3) || (off % n != 0);
`else
        err = 1'b0;
        off = off - off % n;
`endif
        be = '0;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            be[i] = (i >= off) && (i < off + n);
            d[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        m = (64'd1 << (8 * n)) - 64'd1;
        v = ({32'd0, q} >> (8 * off)) & m;
        if (!u && n < 4 && v[8*n-1]) v = v | ~m;
        rd = v[31:0];
    endtask

    task automatic run_txn(input int s, input logic [31:0] a, input logic [1:0] sz, input logic u,
                           input logic w, input logic [31:0] wd, input logic [31:0] q);
        logic err;
        logic [3:0] be;
        logic [31:0] d, rd, erd;
        int lat, rk;
        model(a, sz, u, wd, q, err, be, d, rd);
        lat = s + 1;
        rk = err ? 1 : w ? 2 : 2 + lat;
        erd = (err || w) ? 32'd0 : rd;
        nchk++;
        if (ready[s] !== 1'b1) begin nerr++; $display("FAIL req_ready_idle dut%0d: got %b want 1", s, ready[s]); end
        req_addr = a; req_size = sz; req_unsigned = u; req_write = w; req_wdata = wd;
        reqv[s] = 1'b1;
        if (!err) begin h_addr[s] = a[15:2]; h_be[s] = be; h_data[s] = d; end
        for (int k = 1; k <= rk + 1; k++) begin
            @(posedge clock);
            @(negedge clock);
            reqv[0] = 1'b0; reqv[1] = 1'b0;
            bus_q = (!err && !w && k == 1 + lat) ? q : $urandom;
            nchk += 6;
            if (clken[s] !== (k == 1 && !err)) begin nerr++; $display("FAIL clken dut%0d k=%0d: got %b want %b", s, k, clken[s], k == 1 && !err); end
            if (wren[s] !== (k == 1 && !err && w)) begin nerr++; $display("FAIL wren dut%0d k=%0d: got %b want %b", s, k, wren[s], k == 1 && !err && w); end
            if (baddr[s] !== h_addr[s]) begin nerr++; $display("FAIL bus_address dut%0d k=%0d: got %h want %h", s, k, baddr[s], h_addr[s]); end
            if (bbe[s] !== h_be[s]) begin nerr++; $display("FAIL bus_byteena dut%0d k=%0d: got %b want %b", s, k, bbe[s], h_be[s]); end
            if (bdata[s] !== h_data[s]) begin nerr++; $display("FAIL bus_data dut%0d k=%0d: got %h want %h", s, k, bdata[s], h_data[s]); end
            if (rvalid[s] !== (k == rk)) begin nerr++; $display("FAIL resp_valid dut%0d k=%0d: got %b want %b", s, k, rvalid[s], k == rk); end
            if (k == rk) begin
                nchk += 2;
                if (rerror[s] !== err) begin nerr++; $display("FAIL resp_error dut%0d: got %b want %b", s, rerror[s], err); end
                if (rdata[s] !== erd) begin nerr++; $display("FAIL resp_rdata dut%0d a=%h sz=%0d: got %h want %h", s, a, sz, rdata[s], erd); end
            end
            nchk++;
            if (ready[s] !== (k == rk + 1)) begin nerr++; $display("FAIL req_ready dut%0d k=%0d: got %b want %b", s, k, ready[s], k == rk + 1); end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            nchk++;
            if ({ready[s], rvalid[s], rerror[s], clken[s], wren[s]} !== 5'b10000 || rdata[s] !== 32'd0 ||
                baddr[s] !== 14'd0 || bbe[s] !== 4'd0 || bdata[s] !== 32'd0) begin
                nerr++;
                $display("FAIL reset_values dut%0d: got rdy=%b v=%b e=%b ck=%b wr=%b rd=%h a=%h be=%b d=%h want 1 0 0 0 0 0 0 0 0",
                         s, ready[s], rvalid[s], rerror[s], clken[s], wren[s], rdata[s], baddr[s], bbe[s], bdata[s]);
            end
            h_addr[s] = '0; h_be[s] = '0; h_data[s] = '0;
        end
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        run_txn(0, 32'h0000_0008, 2'd2, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0);
        run_txn(0, 32'h0000_0007, 2'd0, 1'b0, 1'b1, 32'h0000_00A5, 32'h0);
        run_txn(0, 32'h0000_0006, 2'd1, 1'b0, 1'b0, 32'h0, 32'h80FF_1234);
        run_txn(0, 32'h0000_0006, 2'd1, 1'b1, 1'b0, 32'h0, 32'h80FF_1234);
        run_txn(0, 32'h0000_0002, 2'd2, 1'b0, 1'b0, 32'h0, 32'h1357_9BDF);
        run_txn(1, 32'h0000_0001, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0000_7F00);
        run_txn(1, 32'h0000_0003, 2'd3, 1'b1, 1'b1, 32'h1234_5678, 32'h0);
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 300; i++)
            run_txn(int'($urandom_range(1, 0)), $urandom, 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)), $urandom, $urandom);
    endtask

    task automatic test_reset_in_wait();
        req_addr = 32'h0000_0044; req_size = 2'd2; req_unsigned = 1'b0; req_write = 1'b0; req_wdata = $urandom;
        reqv[1] = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clock);
            @(negedge clock);
            reqv[1] = 1'b0;
            bus_q = $urandom;
            nchk += 2;
            if (clken[1] !== (k == 1)) begin nerr++; $display("FAIL rst_wait_clken k=%0d: got %b want %b", k, clken[1], k == 1); end
            if (rvalid[1] !== 1'b0) begin nerr++; $display("FAIL rst_wait_resp k=%0d: got %b want 0", k, rvalid[1]); end
        end
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            nchk++;
            if ({ready[s], rvalid[s], rerror[s], clken[s], wren[s]} !== 5'b10000 || rdata[s] !== 32'd0 ||
                baddr[s] !== 14'd0 || bbe[s] !== 4'd0 || bdata[s] !== 32'd0) begin
                nerr++;
                $display("FAIL rst_wait_values dut%0d: got rdy=%b v=%b e=%b ck=%b wr=%b rd=%h a=%h be=%b d=%h want 1 0 0 0 0 0 0 0 0",
                         s, ready[s], rvalid[s], rerror[s], clken[s], wren[s], rdata[s], baddr[s], bbe[s], bdata[s]);
            end
            h_addr[s] = '0; h_be[s] = '0; h_data[s] = '0;
        end
        reset_n = 1'b1;
        run_txn(1, 32'h0000_0012, 2'd1, 1'b0, 1'b0, 32'h0, 32'hC3A5_0000);
    endtask

    initial begin
        reqv[0] = 1'b0;
        reqv[1] = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back_random();
        test_reset_in_wait();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
